// File: rtl/dff_reg_arbiter_pkg.sv
// Shared defaults and state encoding for the round-robin shared-register arbiter.
`timescale 1ns/1ps
package dff_arb_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;
endpackage

// File: rtl/dff_reg_arbiter_rr_pick.sv
// Combinational round-robin search: first requester with req high at or after ptr, wrapping.
`timescale 1ns/1ps
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    grant,
    output logic             any_req
);
    int idx;

    // Scan offsets from farthest to nearest so the nearest live request wins.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                grant   = idx[PW-1:0];
                any_req = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dff_reg_arbiter.sv
// Shared register written by N_REQ requesters through a round-robin IDLE/WRITE/ACK arbiter.
// Handshake: a requester holds req[i] and its wdata slot until it sees the one-cycle ack[i] pulse.
`timescale 1ns/1ps
module dff_reg_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       CLK,
    input  logic                       res,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           ack,
    output logic [WIDTH-1:0]           Q,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       valid,
    output logic                       busy,
    output state_t                     dbg_state,
    output logic [$clog2(N_REQ)-1:0]   dbg_ptr
);
    localparam int PW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;

    logic [PW-1:0]    pick;
    logic             any_req;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .grant   (pick),
        .any_req (any_req)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        q_d     = q_q;
        owner_d = owner_q;
        valid_d = valid_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A dropped request aborts without touching the register or the pointer.
                if (req[grant_q]) begin
                    q_d            = wdata[int'(grant_q)*WIDTH +: WIDTH];
                    owner_d        = grant_q;
                    valid_d        = 1'b1;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                ptr_d   = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ack       = ack_q;
    assign Q         = q_q;
    assign owner     = owner_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;
endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: driver tasks per scenario, ack monitor popping an expected queue.
`timescale 1ns/1ps
module tb_dff_reg_arbiter;
    import dff_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = 2;
    localparam int EW = PW + W;

    logic            CLK;
    logic            res;
    logic [N-1:0]    req;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    ack;
    logic [W-1:0]    Q;
    logic [PW-1:0]   owner;
    logic            valid;
    logic            busy;
    state_t          dbg_state;
    logic [PW-1:0]   dbg_ptr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0]   exp_q[$];
    logic [EW-1:0]   e;
    logic [PW-1:0]   e_idx;
    logic [W-1:0]    e_data;
    logic [N-1:0]    e_ack;

    dff_reg_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .CLK       (CLK),
        .res       (res),
        .req       (req),
        .wdata     (wdata),
        .ack       (ack),
        .Q         (Q),
        .owner     (owner),
        .valid     (valid),
        .busy      (busy),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ack monitor / scoreboard
    always @(negedge CLK) begin
        if (ack !== '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack ack=%b expected none", ack);
            end else begin
                e      = exp_q.pop_front();
                e_idx  = e[EW-1:W];
                e_data = e[W-1:0];
                e_ack  = '0;
                e_ack[e_idx] = 1'b1;
                n_checks++;
                if (ack !== e_ack) $display("FAIL ack_onehot got=%b exp=%b", ack, e_ack);
                else n_pass++;
                n_checks++;
                if (Q !== e_data) $display("FAIL q_data got=%h exp=%h", Q, e_data);
                else n_pass++;
                n_checks++;
                if (owner !== e_idx) $display("FAIL owner got=%0d exp=%0d", owner, e_idx);
                else n_pass++;
                n_checks++;
                if (valid !== 1'b1) $display("FAIL valid_on_ack got=%b exp=1", valid);
                else n_pass++;
            end
        end
    end

    // driver tasks
    task automatic set_req(input int idx, input logic [W-1:0] data);
        req[idx] = 1'b1;
        wdata[idx*W +: W] = data;
    endtask

    task automatic push_exp(input int idx, input logic [W-1:0] data);
        logic [PW-1:0] i;
        i = idx[PW-1:0];
        exp_q.push_back({i, data});
    endtask

    // Returns number of negedges until ack[idx]; 0 on timeout (reported as a failure).
    task automatic wait_ack(input int idx, output int cycles);
        cycles = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (ack[idx] === 1'b1) begin
                cycles = c;
                break;
            end
        end
        if (cycles == 0) begin
            n_checks++;
            $display("FAIL ack_timeout idx=%0d got=no ack exp=ack within 12 cycles", idx);
        end
    endtask

    task automatic test_reset();
        int cyc;
        res = 1'b1; req = '0; wdata = '0;
        #2;
        n_checks++;
        if (Q !== '0 || valid !== 1'b0 || owner !== '0 || ack !== '0 || busy !== 1'b0)
            $display("FAIL reset_state got Q=%h v=%b o=%0d ack=%b busy=%b exp all zero", Q, valid, owner, ack, busy);
        else n_pass++;
        @(negedge CLK);
        res = 1'b0;
        // preload Q=0xFF via requester 0
        set_req(0, 8'hFF);
        push_exp(0, 8'hFF);
        wait_ack(0, cyc);
        req = '0;
        @(negedge CLK);
        n_checks++;
        if (Q !== 8'hFF || dbg_ptr !== 2'd1) $display("FAIL preload got Q=%h ptr=%0d exp Q=ff ptr=1", Q, dbg_ptr);
        else n_pass++;
        // 15ps reset pulse between edges
        #1;
        res = 1'b1;
        #0.005;
        n_checks++;
        if (Q !== '0 || valid !== 1'b0 || owner !== '0 || dbg_ptr !== '0 || dbg_state !== IDLE)
            $display("FAIL async_reset got Q=%h v=%b o=%0d ptr=%0d st=%0d exp zeros/IDLE", Q, valid, owner, dbg_ptr, dbg_state);
        else n_pass++;
        #0.010;
        res = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        int cyc;
        for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            push_exp(k % N, 8'h10 + 8'(k % N));
            wait_ack(k % N, cyc);
            n_checks++;
            if (cyc !== ((k == 0) ? 2 : 3)) $display("FAIL rr_spacing k=%0d got=%0d exp=%0d", k, cyc, (k == 0) ? 2 : 3);
            else n_pass++;
        end
        req = '0;
        @(negedge CLK);
        n_checks++;
        if (dbg_ptr !== 2'd1 || busy !== 1'b0) $display("FAIL rr_end got ptr=%0d busy=%b exp ptr=1 busy=0", dbg_ptr, busy);
        else n_pass++;
    endtask

    task automatic test_single_write();
        int cyc;
        set_req(2, 8'hA5);
        push_exp(2, 8'hA5);
        wait_ack(2, cyc);
        n_checks++;
        if (cyc !== 2) $display("FAIL single_latency got=%0d exp=2", cyc);
        else n_pass++;
        req = '0;
        @(negedge CLK);
        n_checks++;
        if (Q !== 8'hA5 || owner !== 2'd2 || valid !== 1'b1 || ack !== '0)
            $display("FAIL single_hold got Q=%h o=%0d v=%b ack=%b exp a5/2/1/0", Q, owner, valid, ack);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int cyc;
        n_checks++;
        if (dbg_ptr !== 2'd3) $display("FAIL wrap_ptr_pre got=%0d exp=3", dbg_ptr);
        else n_pass++;
        set_req(1, 8'h5A);
        push_exp(1, 8'h5A);
        wait_ack(1, cyc);
        req = '0;
        @(negedge CLK);
        n_checks++;
        if (owner !== 2'd1 || dbg_ptr !== 2'd2) $display("FAIL wrap_post got o=%0d ptr=%0d exp o=1 ptr=2", owner, dbg_ptr);
        else n_pass++;
    endtask

    task automatic test_abort();
        set_req(0, 8'h33);
        @(negedge CLK);
        n_checks++;
        if (dbg_state !== WRITE || busy !== 1'b1) $display("FAIL abort_in_write got st=%0d busy=%b exp WRITE/1", dbg_state, busy);
        else n_pass++;
        req = '0;
        @(negedge CLK);
        n_checks++;
        if (dbg_state !== IDLE || busy !== 1'b0 || Q !== 8'h5A || owner !== 2'd1 || dbg_ptr !== 2'd2 || ack !== '0)
            $display("FAIL abort_after got st=%0d busy=%b Q=%h o=%0d ptr=%0d ack=%b exp IDLE/0/5a/1/2/0",
                     dbg_state, busy, Q, owner, dbg_ptr, ack);
        else n_pass++;
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        int cyc;
        for (int i = 0; i < N; i++) set_req(i, 8'h10 + 8'(i));
        push_exp(2, 8'h12);
        wait_ack(2, cyc);
        n_checks++;
        if (cyc !== 2) $display("FAIL mid_first_grant got=%0d exp=2 (grant 2 from ptr 2)", cyc);
        else n_pass++;
        #1;
        res = 1'b1;
        #0.005;
        n_checks++;
        if (ack !== '0 || Q !== '0 || dbg_ptr !== '0 || valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_reset got ack=%b Q=%h ptr=%0d v=%b busy=%b exp zeros", ack, Q, dbg_ptr, valid, busy);
        else n_pass++;
        #0.010;
        res = 1'b0;
        push_exp(0, 8'h10);
        wait_ack(0, cyc);
        n_checks++;
        if (cyc !== 2) $display("FAIL mid_next_grant got=%0d exp=2", cyc);
        else n_pass++;
        req = '0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_write();
        test_wrap();
        test_abort();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
